// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Open-drain pad control: inhibit, request-to-send, bit shift, ack/idle wait.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       nack,
  output logic       timeout
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                           INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [9:0]    frame;

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;
  logic       clk_s;
  logic       data_s;
  logic       fall;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall   = clk_prev & ~clk_s;

  // Idle bus reads high, so sync flops reset to 1 to avoid a false fall.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_s;
    end
  end

  assign tx_ready = (state == S_IDLE) && !done;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= 4'd0;
      frame       <= 10'd0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      nack        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid && tx_ready) begin
            frame      <= {1'b1, ~^tx_data, tx_data};
            cnt        <= '0;
            nack       <= 1'b0;
            timeout    <= 1'b0;
            ps2_clk_oe <= 1'b1;
            state      <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt         <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            state       <= S_REQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_REQ: begin
          idx   <= 4'd0;
          cnt   <= '0;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          // A fall wins over a coincident timeout expiry.
          if (fall) begin
            cnt <= '0;
            if (idx == 4'd10) begin
              nack        <= data_s;
              ps2_data_oe <= 1'b0;
              state       <= S_WAIT;
            end else begin
              ps2_data_oe <= ~frame[idx];
              idx         <= idx + 4'd1;
            end
          end else if (cnt == TO_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b1;
            timeout     <= 1'b1;
            nack        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (clk_s && data_s) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (cnt == TO_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b1;
            timeout     <= 1'b1;
            nack        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model.
// Stimulus pushes expected results; a done-driven monitor pops and compares.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       clk_oe;
  logic       data_oe;
  logic       done;
  logic       nack;
  logic       timeout;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  wire  clk_pad  = !(clk_oe || dev_clk_low);
  wire  data_pad = !(data_oe || dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx dut (
    .clk_core    (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (clk_pad),
    .ps2_data_in (data_pad),
    .ps2_clk_oe  (clk_oe),
    .ps2_data_oe (data_oe),
    .done        (done),
    .nack        (nack),
    .timeout     (timeout)
  );

  typedef struct {
    logic [10:0] bits;
    logic        xn;
    logic        xt;
    logic        ck;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int pass_cnt = 0;
  int total_cnt = 0;

  int          dev_mode = 0;
  int          dev_falls = 0;
  logic        dev_busy = 1'b0;
  logic [10:0] dev_bits = '0;
  logic [10:0] dev_shift = '0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic fail_now(input string nm);
    total_cnt++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Device model: 0 = ack, 1 = nack, 2 = absent.
  initial begin
    forever begin
      @(negedge clk);
      if (dev_mode != 2 && !dev_busy && clk_pad && !data_pad) begin
        dev_busy  = 1'b1;
        dev_falls = 0;
        repeat (5) @(negedge clk);
        dev_shift[0] = data_pad;
        for (int k = 1; k <= 10; k++) begin
          dev_clk_low = 1'b1;
          dev_falls++;
          repeat (10) @(negedge clk);
          dev_clk_low = 1'b0;
          repeat (10) @(negedge clk);
          dev_shift[k] = data_pad;
        end
        dev_bits = dev_shift;
        if (dev_mode == 0) dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        dev_falls++;
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        fail_now("unexpected done");
      end else begin
        e = sb.pop_front();
        check({e.nm, " nack"}, 32'(nack), 32'(e.xn));
        check({e.nm, " timeout"}, 32'(timeout), 32'(e.xt));
        check({e.nm, " ready low at done"}, 32'(tx_ready), 32'd0);
        if (e.ck)
          check({e.nm, " wire bits"}, 32'(dev_bits), 32'(e.bits));
      end
    end
  end

  task automatic measure_inhibit(input string nm);
    int n = 0;
    while (clk_oe && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check({nm, " inhibit cycles"}, n, 2500);
    check({nm, " req oe"}, 32'({clk_oe, data_oe}), 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic xn,
                      input logic xt, input logic ck, input string nm);
    int n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) fail_now({nm, " ready wait"});
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    sb.push_back('{bits: {1'b1, p, d, 1'b0}, xn: xn, xt: xt, ck: ck, nm: nm});
    measure_inhibit(nm);
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60000);
    if (!done) fail_now({nm, " done wait"});
  endtask

  task automatic wait_dev_idle(input string nm);
    int n = 0;
    while (dev_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (dev_busy) fail_now({nm, " device idle wait"});
  endtask

  task automatic run_frame(input logic [7:0] d, input logic p,
                           input int mode, input logic xn, input string nm);
    int n;
    dev_mode = mode;
    send(d, p, xn, 1'b0, 1'b1, nm);
    wait_done(nm, n);
    wait_dev_idle(nm);
  endtask

  initial begin
    int n;
    int cnt;
    repeat (3) @(negedge clk);
    check("rst ready", 32'(tx_ready), 32'd1);
    check("rst oe", 32'({clk_oe, data_oe}), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst nack", 32'(nack), 32'd0);
    check("rst timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Hand-computed odd parity: ED->1, F4->0, 00->1, FF->1, AA->1.
    run_frame(8'hED, 1'b1, 0, 1'b0, "ed");
    run_frame(8'hF4, 1'b0, 0, 1'b0, "f4");
    run_frame(8'h00, 1'b1, 0, 1'b0, "00");
    run_frame(8'hFF, 1'b1, 0, 1'b0, "ff");
    run_frame(8'hF4, 1'b0, 1, 1'b1, "f4 nack");

    // 50000 SHIFT cycles follow the single REQ cycle.
    dev_mode = 2;
    send(8'hED, 1'b1, 1'b0, 1'b1, 1'b0, "tmo");
    wait_done("tmo", n);
    check("tmo cycles from req", n, 50001);
    check("tmo oe released", 32'({clk_oe, data_oe}), 32'd0);
    repeat (5) @(negedge clk);
    dev_mode = 0;

    send(8'hED, 1'b1, 1'b0, 1'b0, 1'b1, "rst mid");
    n = 0;
    while (dev_falls < 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (dev_falls < 5) fail_now("rst mid bit4 wait");
    repeat (12) @(negedge clk);
    check("rst mid bit4 low", 32'(data_oe), 32'd1);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst mid oe", 32'({clk_oe, data_oe}), 32'd0);
    check("rst mid ready", 32'(tx_ready), 32'd1);
    check("rst mid done", 32'(done), 32'd0);
    reset = 1'b0;
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("rst mid no done", cnt, 0);
    wait_dev_idle("rst mid");
    run_frame(8'hF4, 1'b0, 0, 1'b0, "post rst f4");

    dev_mode = 0;
    send(8'hED, 1'b1, 1'b0, 1'b0, 1'b1, "hold1");
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    cnt = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (tx_ready) cnt++;
    end while (!done && n < 60000);
    if (!done) fail_now("hold1 done wait");
    check("hold no early ready", cnt, 0);
    sb.push_back('{bits: {1'b1, 1'b1, 8'hAA, 1'b0}, xn: 1'b0, xt: 1'b0,
                   ck: 1'b1, nm: "hold2"});
    @(negedge clk);
    check("hold ready after done", 32'(tx_ready), 32'd1);
    check("hold not yet inhibit", 32'(clk_oe), 32'd0);
    @(negedge clk);
    tx_valid = 1'b0;
    check("hold accepted", 32'(clk_oe), 32'd1);
    measure_inhibit("hold2");
    wait_done("hold2", n);
    wait_dev_idle("hold2");

    repeat (20) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Hardware transmitter for host-to-device PS/2 commands, e.g. keyboard "set LEDs" 0xED or "enable" 0xF4.
- It is the outbound counterpart to the existing PS/2 clock input path. That path is open-drain, read through the input port, and can be pulled low under software control.
- Drives the PS/2 clock and data pads as open-drain: an SB_IO output-enable with D_OUT tied to 0. Sits beside ico_soc in the clk_core domain.
- Software or a keyboard controller hands it a byte. It runs the inhibit/request-to-send/shift/ack sequence and reports completion status.

Parameters:
- INHIBIT_CYCLES, 2500, clk_core cycles the clock line is held low before request-to-send. Must be at least 100 µs.
- TIMEOUT_CYCLES, 50000, maximum clk_core cycles between consecutive device clock falling edges, and for the final bus-idle wait, before aborting.

Ports:
- clk_core  input  1  core clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send.
- tx_valid  input  1  request; accepted when tx_valid & tx_ready.
- tx_ready  output  1  high only in IDLE.
- ps2_clk_in  input  1  raw PS/2 clock pad level (asynchronous).
- ps2_data_in  input  1  raw PS/2 data pad level (asynchronous).
- ps2_clk_oe  output  1  1 = pull clock line low.
- ps2_data_oe  output  1  1 = pull data line low.
- done  output  1  one-cycle pulse at end of transfer.
- nack  output  1  valid with done: device ack bit was 1.
- timeout  output  1  valid with done: transfer aborted on timeout.

Behaviour:
- Input synchronization:
  - ps2_clk_in and ps2_data_in each pass through 2 flops before use.
  - fall = previous synced clk 1 and current synced clk 0.
  - One fall event per device clock; latency 2–3 cycles from pad edge.
- Reset:
  - State goes to IDLE; ps2_clk_oe=0, ps2_data_oe=0, done=0, nack=0, timeout=0, tx_ready=1; all counters cleared.
  - Reset mid-transfer releases both lines on the next edge. No done pulse is issued.
- IDLE:
  - tx_ready=1, both oe=0.
  - On accept: latch frame = {stop 1, parity, tx_data}. Parity = ~^tx_data (odd parity).
  - Clear counter; go to INHIBIT.
  - tx_valid while not ready is ignored; no queuing.
- INHIBIT:
  - ps2_clk_oe=1, ps2_data_oe=0, for exactly INHIBIT_CYCLES cycles.
  - Then go to REQ.
- REQ (one cycle):
  - ps2_data_oe=1 (start bit 0); ps2_clk_oe=0.
  - bit index=0, timeout counter cleared. Go to SHIFT.
- SHIFT:
  - On each fall with index 0..9, present frame[index]: ps2_data_oe = ~frame[index], so a 0 is driven low and a 1 is released.
  - Then increment index. Index 9 is the stop bit, so data is released.
  - On the fall with index 10, sample synced data: nack = data.
  - Then go to WAIT_IDLE.
  - The timeout counter resets on every fall.
- WAIT_IDLE:
  - Both oe=0. Wait until synced clk=1 and synced data=1.
  - Then pulse done and go to IDLE. tx_ready rises the cycle after done.
- Timeout:
  - In SHIFT or WAIT_IDLE, if the counter reaches TIMEOUT_CYCLES, release both lines.
  - Pulse done with timeout=1 and nack=0; go to IDLE.
  - A device absent from the start is caught in SHIFT, since no falls arrive.
- Status hold: nack and timeout hold their value until the next accept, which clears them.
- Simultaneous events: a fall and timeout expiry in the same cycle count as the fall. Frame bit order is LSB first.
- Overlapping drive: ps2_clk_oe and ps2_data_oe are never both 1, except that data_oe may go high in REQ the same edge clock_oe drops.

Test Plan:
- Accept 0xED → clk_oe high for exactly 2500 cycles; then data low. Device model clocks 11 times; the data seen at its rising edges is 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1. Model acks low → done=1, nack=0, timeout=0.
- Accept 0xF4 → parity bit observed 0. 0x00 and 0xFF → parity 1.
- Model leaves data high at the 11th clock → done with nack=1.
- No device clocks after REQ → done after exactly 50000 cycles with timeout=1; both oe=0.
- Assert reset during bit 4 of 0xED → next cycle both oe=0, tx_ready=1, no done. A following 0xF4 completes cleanly.
- Hold tx_valid with 0xAA during a transfer → not accepted until the cycle after done. A second frame then starts with a fresh INHIBIT.
